// File: rtl/seq_sub_unit.sv
// seq_sub_unit: bit-serial a-b engine with five mode-selected, individually held result outputs
module seq_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       seq,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   diff_u,
  output logic [WIDTH:0]   diff_s,
  output logic [WIDTH-1:0] diff_wrap,
  output logic [WIDTH-1:0] diff_usat,
  output logic [WIDTH-1:0] diff_ssat,
  output logic             running,
  output logic             done,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state;
  logic [2:0] mode;
  logic [WIDTH:0] sa, sb, r;
  logic carry, bit_sum, sx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] smax, smin;
  assign sx = (seq == 3'd1) || (seq == 3'd4);
  assign bit_sum = sa[0] ^ ~sb[0] ^ carry;
  assign smax = {1'b0, {(WIDTH-1){1'b1}}};
  assign smin = {1'b1, {(WIDTH-1){1'b0}}};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode <= '0;
      sa <= '0;
      sb <= '0;
      r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      diff_u <= '0;
      diff_s <= '0;
      diff_wrap <= '0;
      diff_usat <= '0;
      diff_ssat <= '0;
      running <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode <= seq;
          sa <= {sx & a[WIDTH-1], a};
          sb <= {sx & b[WIDTH-1], b};
          carry <= 1'b1;
          cnt <= '0;
          running <= 1'b1;
          state <= (seq >= 3'd5) ? FINISH : SHIFT;
        end
        SHIFT: begin
          r <= {bit_sum, r[WIDTH:1]};
          carry <= (sa[0] & ~sb[0]) | (carry & (sa[0] ^ ~sb[0]));
          sa <= sa >> 1;
          sb <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) state <= FINISH;
        end
        default: begin
          if (mode == 3'd0) diff_u <= r;
          if (mode == 3'd1) diff_s <= r;
          if (mode == 3'd2) diff_wrap <= r[WIDTH-1:0];
          if (mode == 3'd3) diff_usat <= r[WIDTH] ? '0 : r[WIDTH-1:0];
          // signed overflow of the WIDTH-bit view shows as disagreement of the top two bits
          if (mode == 3'd4) diff_ssat <= (r[WIDTH] == r[WIDTH-1]) ? r[WIDTH-1:0] : (r[WIDTH] ? smin : smax);
          err <= mode >= 3'd5;
          running <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_sub_unit.md
Name: seq_sub_unit

Overview:
- Sequenced, bit-serial subtract engine. Responder to the start/seq/running/done command handshake that the arithmetic benches drive.
- Latches operands a and b on start and computes a-b one bit per cycle.
- The result is delivered on one of five mode-specific outputs (unsigned/signed extended, wrap, unsigned/signed saturate), selected by seq.
- It is the inverse-operation companion to the sequenced adder and shares the same command protocol.

Parameters:
- WIDTH, 4, operand width in bits (>=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- seq  in  3  mode select, latched with start.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- diff_u  out  WIDTH+1  mode 0: zero-extended a minus zero-extended b, two's complement.
- diff_s  out  WIDTH+1  mode 1: sign-extended a minus sign-extended b.
- diff_wrap  out  WIDTH  mode 2: (a-b) mod 2^WIDTH.
- diff_usat  out  WIDTH  mode 3: unsigned a-b, clamped at 0.
- diff_ssat  out  WIDTH  mode 4: signed a-b, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- running  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse when outputs are updated.
- err  out  1  set on completion of an illegal mode (seq 5..7), cleared on next legal completion.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including running, done and err.
  - Internal operand, borrow and count registers are cleared.
  - Reset overrides any in-progress command; no done pulse is produced for it.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - done is high only in the first IDLE cycle after FINISH; otherwise 0.
  - On start=1, latch seq, a and b into shift registers.
  - Extension of the latched operands to WIDTH+1 bits:
    - Modes 1 and 4: sign-extend.
    - Modes 0, 2 and 3: zero-extend.
  - Set carry=1 (a + ~b + 1 form), clear cnt, go to SHIFT.
  - seq 5..7: go directly to FINISH, skipping SHIFT.
  - start is accepted in the same cycle done is high.
- SHIFT:
  - running=1.
  - Each cycle: compute bit cnt = a_bit ^ ~b_bit ^ carry, update carry, shift the result bit into the result register LSB-first, increment cnt.
  - After WIDTH+1 cycles (cnt == WIDTH), go to FINISH.
- FINISH:
  - running=1.
  - On the edge leaving FINISH, write only the selected output; the other four outputs hold their previous values.
  - Let r be the (WIDTH+1)-bit result.
    - Mode 0 writes diff_u=r.
    - Mode 1 writes diff_s=r.
    - Mode 2 writes diff_wrap=r[WIDTH-1:0].
    - Mode 3 writes diff_usat = 0 if r[WIDTH] (borrow, a<b), else r[WIDTH-1:0].
    - Mode 4 writes diff_ssat, with r treated as signed: 2^(WIDTH-1)-1 if r > that value, -2^(WIDTH-1) if r < that value, else r[WIDTH-1:0].
  - err = (seq>=5).
  - Go to IDLE and assert done for one cycle.
- Latency: start sampled at edge E0 (legal mode) gives:
  - running=1 from after E0 through E(WIDTH+2);
  - outputs and done valid after E(WIDTH+2);
  - i.e. WIDTH+2 running cycles; for WIDTH=4 that is 6 running cycles.
  - Illegal mode: 1 running cycle (FINISH only), then done.
- Input rules:
  - start while running=1 is ignored.
  - a, b and seq may change freely after the start cycle; the latched copies are used.
- Width rules: diff_u and diff_s never overflow (WIDTH+1 bits). Saturation decisions use the full WIDTH+1-bit r.

Test Plan:
- Reset mid-operation: start with a=5, b=3, seq=0, then assert reset on the 3rd running cycle → running=0, done never pulses, diff_u stays 0, and a following command completes normally.
- Unsigned, WIDTH=4, a=3, b=5:
  - seq=0 → diff_u=5'b11110 (30).
  - seq=2 → diff_wrap=14.
  - seq=3 → diff_usat=0.
  - Each command: running high exactly 6 cycles, then a 1-cycle done.
- Signed, WIDTH=4:
  - a=4'b0111 (7), b=4'b1000 (-8): seq=1 → diff_s=15; seq=4 → diff_ssat=7.
  - a=4'b1000 (-8), b=4'b0001 (1): seq=4 → diff_ssat=-8 (4'b1000); seq=1 → diff_s=-9 (5'b10111).
- Handshake: start pulsed again during running is ignored (one done only). start asserted in the done cycle with a=9, b=2, seq=2 is accepted → diff_wrap=7 after 6 more running cycles.
- Illegal mode: seq=6 → running for 1 cycle, done pulse, err=1, all diff outputs unchanged. A following seq=0 command clears err to 0.
- Exhaustive check: all 16×16 (a,b) pairs × seq 0..4 sequenced through the handshake, each output compared against a behavioural reference model; the final pass flag must be 1.
